// File: rtl/i2c_fmt_fifo.sv
// rtl/i2c_fmt_fifo.sv - I2C format-command FIFO, first-word-fall-through, 13-bit entries
// Optional low-watermark status is built when I2C_FMT_FIFO_THRESH_EN is defined.
module i2c_fmt_fifo #(
   parameter  int FifoDepth      = 64,
   localparam int FifoDepthWidth = $clog2(FifoDepth + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      fmt_fifo_flush_i,
   input  logic                      fmt_fifo_wvalid_i,
   input  logic [12:0]               fmt_fifo_wdata_i,
   output logic                      fmt_fifo_wready_o,
   output logic                      fmt_fifo_rvalid_o,
   input  logic                      fmt_fifo_rready_i,
   output logic [FifoDepthWidth-1:0] fmt_fifo_depth_o,
   output logic [7:0]                fmt_byte_o,
   output logic                      fmt_flag_start_before_o,
   output logic                      fmt_flag_stop_after_o,
   output logic                      fmt_flag_read_bytes_o,
   output logic                      fmt_flag_read_continue_o,
   output logic                      fmt_flag_nak_ok_o,
   input  logic [FifoDepthWidth-1:0] fmt_thresh_i,
   output logic                      fmt_threshold_o,
   output logic                      fmt_overflow_o
);

   localparam int PtrWidth = $clog2(FifoDepth);
   localparam logic [PtrWidth-1:0]       PtrLast  = PtrWidth'(FifoDepth - 1);
   localparam logic [FifoDepthWidth-1:0] CountMax = FifoDepthWidth'(FifoDepth);

   logic [12:0]               r_mem [FifoDepth];
   logic [PtrWidth-1:0]       r_wptr;
   logic [PtrWidth-1:0]       r_rptr;
   logic [FifoDepthWidth-1:0] r_count;
   logic                      r_overflow;
   logic                      r_threshold;

   logic                      w_full;
   logic                      w_empty;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_clear;
   logic [FifoDepthWidth-1:0] w_count_next;
   logic [12:0]               w_head;

   assign w_full  = (r_count == CountMax);
   assign w_empty = (r_count == '0);
   assign w_clear = rst_i | fmt_fifo_flush_i;
   // Full-ness comes from registered state only, so a same-cycle pop never frees a slot.
   assign w_push  = fmt_fifo_wvalid_i & ~w_full;
   assign w_pop   = fmt_fifo_rready_i & ~w_empty;

   always_comb begin
      w_count_next = r_count;
      if (w_clear) begin
         w_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push && !w_clear) begin
         r_mem[r_wptr] <= fmt_fifo_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_clear) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= fmt_fifo_wvalid_i & w_full;
      end
   end

`ifdef I2C_FMT_FIFO_THRESH_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_threshold <= 1'b0;
      end else begin
         r_threshold <= (w_count_next < fmt_thresh_i);
      end
   end
`else
   logic w_unused_thresh;
   assign w_unused_thresh = ^fmt_thresh_i;
   always_ff @(posedge clk_i) begin
      r_threshold <= 1'b0;
   end
`endif

   assign w_head = r_mem[r_rptr];

   assign fmt_fifo_wready_o        = ~w_full;
   assign fmt_fifo_rvalid_o        = ~w_empty;
   assign fmt_fifo_depth_o         = r_count;
   assign fmt_byte_o               = w_head[7:0];
   assign fmt_flag_start_before_o  = w_head[8];
   assign fmt_flag_stop_after_o    = w_head[9];
   assign fmt_flag_read_bytes_o    = w_head[10];
   assign fmt_flag_read_continue_o = w_head[11];
   assign fmt_flag_nak_ok_o        = w_head[12];
   assign fmt_threshold_o          = r_threshold;
   assign fmt_overflow_o           = r_overflow;

endmodule

// File: tb/tb_i2c_fmt_fifo.sv
// tb/tb_i2c_fmt_fifo.sv - scoreboard bench for i2c_fmt_fifo with FifoDepth=4
module tb_i2c_fmt_fifo;

   localparam int D  = 4;
   localparam int DW = $clog2(D + 1);
`ifdef I2C_FMT_FIFO_THRESH_EN
   localparam bit ThrEn = 1'b1;
`else
   localparam bit ThrEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          wvalid = 1'b0;
   logic [12:0]   wdata = '0;
   logic          wready;
   logic          rvalid;
   logic          rready = 1'b0;
   logic [DW-1:0] depth;
   logic [7:0]    fbyte;
   logic          f_start, f_stop, f_rb, f_rc, f_nak;
   logic [DW-1:0] thresh = DW'(2);
   logic          threshold;
   logic          overflow;

   int total = 0;
   int bad   = 0;
   int m_count = 0;
   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   i2c_fmt_fifo #(.FifoDepth(D)) dut (
      .clk_i                    (clk),
      .rst_i                    (rst),
      .fmt_fifo_flush_i         (flush),
      .fmt_fifo_wvalid_i        (wvalid),
      .fmt_fifo_wdata_i         (wdata),
      .fmt_fifo_wready_o        (wready),
      .fmt_fifo_rvalid_o        (rvalid),
      .fmt_fifo_rready_i        (rready),
      .fmt_fifo_depth_o         (depth),
      .fmt_byte_o               (fbyte),
      .fmt_flag_start_before_o  (f_start),
      .fmt_flag_stop_after_o    (f_stop),
      .fmt_flag_read_bytes_o    (f_rb),
      .fmt_flag_read_continue_o (f_rc),
      .fmt_flag_nak_ok_o        (f_nak),
      .fmt_thresh_i             (thresh),
      .fmt_threshold_o          (threshold),
      .fmt_overflow_o           (overflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pop the DUT will perform at the next edge is compared with the scoreboard head.
   always @(negedge clk) begin
      logic [12:0] act;
      logic [12:0] exp;
      if (!rst && !flush && rvalid && rready) begin
         act = {f_nak, f_rc, f_rb, f_stop, f_start, fbyte};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h expected none", act);
         end else begin
            exp = exp_q.pop_front();
            chk("pop_entry", int'(act), int'(exp));
         end
      end
   end

   task automatic step(input logic wv, input logic [12:0] wd, input logic rr,
                       input logic fl, input logic rs);
      logic acc_w, acc_r, exp_ovf, exp_thr;
      int   nxt;
      rst = rs; flush = fl; wvalid = wv; wdata = wd; rready = rr;
      acc_w   = wv && (m_count != D);
      acc_r   = rr && (m_count != 0);
      exp_ovf = wv && (m_count == D) && !fl && !rs;
      if (rs || fl) nxt = 0;
      else          nxt = m_count + int'(acc_w) - int'(acc_r);
      exp_thr = ThrEn && !rs && (nxt < int'(thresh));
      @(posedge clk);
      if (rs || fl) exp_q.delete();
      else if (acc_w) exp_q.push_back(wd);
      m_count = nxt;
      #1;
      chk("depth", int'(depth), m_count);
      chk("rvalid", int'(rvalid), int'(m_count != 0));
      chk("wready", int'(wready), int'(m_count != D));
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("threshold", int'(threshold), int'(exp_thr));
   endtask

   task automatic wr(input logic [12:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 13'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      step(1'b0, 13'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 13'h0, 1'b0, 1'b0, 1'b0);

      wr(13'h1A5); wr(13'h03C); wr(13'h07F);
      pop(); pop(); pop();
      pop();

      wr(13'h011); wr(13'h022); wr(13'h433); wr(13'h844); wr(13'h055);
      step(1'b0, 13'h0, 1'b0, 1'b0, 1'b0);
      pop(); pop(); pop(); pop();

      wr(13'h301); wr(13'h502); wr(13'h903); wr(13'h104);
      step(1'b1, 13'h1FF, 1'b1, 1'b0, 1'b0);
      pop();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 13'(13'h0C0 + i * 13'h111), 1'b1, 1'b0, 1'b0);
      end
      pop(); pop();

      wr(13'h0AA); wr(13'h0BB); wr(13'h0CC);
      step(1'b1, 13'h0DD, 1'b1, 1'b1, 1'b0);
      step(1'b0, 13'h0, 1'b0, 1'b0, 1'b0);

      wr(13'h061); wr(13'h062); wr(13'h063);
      pop(); pop(); pop();
      step(1'b0, 13'h0, 1'b0, 1'b0, 1'b0);

      wr(13'h271); wr(13'h272);
      step(1'b1, 13'h273, 1'b0, 1'b0, 1'b1);
      wr(13'h1EE);
      pop();

      step(1'b0, 13'h0, 1'b0, 1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
